load_fetch_ctrl: RTL and testbench
==================================

LOAD_FETCH_CTRL -- requirements
Module: load_fetch_ctrl

Interface
REQ-001 SHALL have parameter: ADDR_W, 32, byte-address width.
REQ-002 SHALL have ports:
- i_clk  in  1  sole clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_req_valid  in  1  load request from execute stage.
- o_req_ready  out  1  request accepted when high with i_req_valid.
- i_addr  in  ADDR_W  load byte address.
- i_funct3  in  3  load type: LB=000, LH=001, LW=010, LBU=100, LHU=101.
- o_mem_req  out  1  data-memory word read request.
- o_mem_addr  out  ADDR_W  word-aligned read address, low 2 bits 00.
- i_mem_ack  in  1  read data valid this cycle.
- i_mem_rdata  in  32  read word.
- o_valid  out  1  word pair ready for load-alignment stage.
- i_ready  in  1  downstream accepts o_valid.
- o_data1  out  32  word at aligned address.
- o_data2  out  32  following word, or 0.
- o_funct3  out  3  latched funct3.
- o_lsu_addr  out  2  latched i_addr[1:0].
- o_misalign_err  out  1  unsupported misaligned load, valid with o_valid.

Function
REQ-003 SHALL implement FSM states IDLE, RD1, RD2, DONE; encoding free.
REQ-004 IDLE: o_req_ready=1; on i_req_valid, latch i_addr, i_funct3; next state RD1. All other states: o_req_ready=0.
REQ-005 Spanning load: LH/LHU with addr[1:0]=11; LW with addr[1:0]!=00; LB/LBU never span.
REQ-006 RD1: o_mem_req=1, o_mem_addr={addr[ADDR_W-1:2],00}, held stable until i_mem_ack; on ack, capture i_mem_rdata into o_data1; go RD2 if spanning, else DONE.
REQ-007 RD2: o_mem_req=1, o_mem_addr = RD1 address + 4, wrapping modulo 2^ADDR_W (0xFFFFFFFC -> 0x00000000); on ack, capture into o_data2; go DONE.
REQ-008 Non-spanning loads: o_data2=0.
REQ-009 Undefined funct3 (011, 110, 111): no memory request; RD1 skipped; DONE with o_data1=o_data2=0.
REQ-010 DONE: o_valid=1, outputs stable until i_ready; on i_ready go IDLE. New request not accepted in the same cycle.
REQ-011 Latency with ack in same cycle as req: o_valid high 2 cycles after acceptance (non-spanning), 3 cycles (spanning).
REQ-012 i_mem_ack outside RD1/RD2 SHALL be ignored.
REQ-013 o_mem_req SHALL NOT be deasserted before ack, except by reset.

Reset
REQ-014 i_rst SHALL force IDLE immediately, mid-transaction included, with no new memory request issued.
REQ-015 Reset values: o_req_ready=1 (after reset release), o_mem_req=0, o_mem_addr=0, o_valid=0, o_data1=0, o_data2=0, o_funct3=0, o_lsu_addr=0, o_misalign_err=0.

Configuration
REQ-016 Macro LSU_MISALIGN_EN defined: spanning loads use RD2 per REQ-006/007; o_misalign_err=0 always.
REQ-017 LSU_MISALIGN_EN undefined: spanning load goes IDLE->DONE, no memory request; o_data1=o_data2=0, o_misalign_err=1 while o_valid; RD2 unreachable.

Structure
REQ-018 Shared package lsu_pkg SHALL hold the funct3 load-type constants and the FSM state typedef.
REQ-019 Spanning detection SHALL be the combinational sub-module lsu_span_detect (funct3, addr[1:0] -> span flag).

Verification
REQ-020 LW at 0x100, ack in the req cycle, rdata 0x11223344 -> one read at 0x100; o_data1=0x11223344, o_data2=0; o_valid 2 cycles after acceptance.
REQ-021 LW at 0x103 (LSU_MISALIGN_EN) -> reads 0x100 then 0x104; o_data1/o_data2 = the two words; o_lsu_addr=11.
REQ-022 LH at 0xFFFFFFFF -> second read address 0x00000000.
REQ-023 LHU at 0x102, ack delayed 3 cycles, i_ready low 2 cycles in DONE -> o_mem_addr stable while waiting; outputs held until i_ready.
REQ-024 i_rst asserted in RD2 -> o_mem_req=0 and IDLE immediately; late ack after release ignored; next request correct.
REQ-025 funct3=011 -> no o_mem_req; o_valid with zero data. Without LSU_MISALIGN_EN, LW at 0x102 -> o_misalign_err=1, no read.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared load-unit definitions: funct3 load-type encodings and the fetch FSM state type.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    RD1,
    RD2,
    DONE
  } state_t;

  function automatic logic is_load_f3(input logic [2:0] f3);
    return f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
  endfunction

endpackage

// File: rtl/lsu_span_detect.sv
// Flags loads whose bytes cross a 32-bit word boundary.
module lsu_span_detect
  import lsu_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [1:0] addr_lo,
  output logic       span
);

  always_comb begin
    span = 1'b0;
    case (funct3)
      F3_LH, F3_LHU: span = (addr_lo == 2'b11);
      F3_LW:         span = (addr_lo != 2'b00);
      default:       span = 1'b0;
    endcase
  end

endmodule

// File: rtl/load_fetch_ctrl.sv
// Load fetch controller: reads one or two aligned words for the load-alignment stage.
// Build option LSU_MISALIGN_EN: word-spanning loads fetch a second word instead of raising o_misalign_err.
module load_fetch_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [2:0]        i_funct3,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_ack,
  input  logic [31:0]       i_mem_rdata,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [31:0]       o_data1,
  output logic [31:0]       o_data2,
  output logic [2:0]        o_funct3,
  output logic [1:0]        o_lsu_addr,
  output logic              o_misalign_err
);

`ifdef LSU_MISALIGN_EN
  localparam bit MisalignEn = 1'b1;
`else
  localparam bit MisalignEn = 1'b0;
`endif

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] rd1_addr;
  logic [2:0]        funct3_q;
  logic              span_q;
  logic              span_in;
  logic              err_q;
  logic [31:0]       data1_q;
  logic [31:0]       data2_q;
  logic              accept;
  logic              go_rd1;

  lsu_span_detect u_span_detect (
    .funct3  (i_funct3),
    .addr_lo (i_addr[1:0]),
    .span    (span_in)
  );

  assign accept   = (state == IDLE) && i_req_valid;
  // Undefined funct3, or a spanning load without misalign support, completes with no memory access.
  assign go_rd1   = is_load_f3(i_funct3) && (MisalignEn || !span_in);
  assign rd1_addr = {addr_q[ADDR_W-1:2], 2'b00};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (i_req_valid) state_nxt = go_rd1 ? RD1 : DONE;
      RD1:  if (i_mem_ack)   state_nxt = (MisalignEn && span_q) ? RD2 : DONE;
      RD2:  if (i_mem_ack)   state_nxt = DONE;
      DONE: if (i_ready)     state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr_q   <= '0;
      funct3_q <= '0;
      span_q   <= 1'b0;
      err_q    <= 1'b0;
      data1_q  <= '0;
      data2_q  <= '0;
    end else begin
      if (accept) begin
        addr_q   <= i_addr;
        funct3_q <= i_funct3;
        span_q   <= span_in;
        err_q    <= !MisalignEn && is_load_f3(i_funct3) && span_in;
        data1_q  <= '0;
        data2_q  <= '0;
      end
      if (state == RD1 && i_mem_ack) data1_q <= i_mem_rdata;
      if (state == RD2 && i_mem_ack) data2_q <= i_mem_rdata;
    end
  end

  always_comb begin
    o_req_ready    = (state == IDLE);
    o_mem_req      = (state == RD1) || (state == RD2);
    o_valid        = (state == DONE);
    o_misalign_err = err_q && (state == DONE);
    o_mem_addr     = '0;
    case (state)
      RD1:     o_mem_addr = rd1_addr;
      RD2:     o_mem_addr = rd1_addr + ADDR_W'(4);
      default: o_mem_addr = '0;
    endcase
  end

  assign o_data1    = data1_q;
  assign o_data2    = data2_q;
  assign o_funct3   = funct3_q;
  assign o_lsu_addr = addr_q[1:0];

endmodule

// File: tb/tb_load_fetch_ctrl.sv
// Scoreboard bench for load_fetch_ctrl: memory responder, output monitor, directed load vectors.
module tb_load_fetch_ctrl;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_addr;
  logic [2:0]  i_funct3;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [31:0] o_data1, o_data2;
  logic [2:0]  o_funct3;
  logic [1:0]  o_lsu_addr;
  logic        o_misalign_err;

  logic        resp_ack = 1'b0, stray_ack = 1'b0;
  logic [31:0] resp_data = '0, stray_data = '0;
  assign i_mem_ack   = resp_ack | stray_ack;
  assign i_mem_rdata = stray_ack ? stray_data : resp_data;

  load_fetch_ctrl #(.ADDR_W(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_addr(i_addr), .i_funct3(i_funct3), .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata), .o_valid(o_valid), .i_ready(i_ready),
    .o_data1(o_data1), .o_data2(o_data2), .o_funct3(o_funct3), .o_lsu_addr(o_lsu_addr),
    .o_misalign_err(o_misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d1, d2;
    logic [2:0]  f3;
    logic [1:0]  la;
    logic        err;
    int          hold;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  int checks = 0, errors = 0, cyc = 0, ack_delay = 0;
  bit in_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h1122_3344;
      32'h0000_0104: return 32'h5566_7788;
      32'h0000_0000: return 32'hCAFE_F00D;
      32'hFFFF_FFFC: return 32'hDEAD_BEEF;
      default:       return {a[15:0], ~a[15:0]};
    endcase
  endfunction

  // Memory responder: checks each read address and answers after ack_delay cycles.
  initial begin
    bit          in_req = 1'b0;
    int          cnt = 0;
    logic [31:0] cur = '0;
    forever begin
      @(negedge clk);
      resp_ack = 1'b0;
      if (o_mem_req) begin
        if (!in_req) begin
          in_req = 1'b1;
          cnt = 0;
          cur = o_mem_addr;
          if (addr_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_mem_req actual=%h expected=none", o_mem_addr);
          end else chk("mem_addr", o_mem_addr, addr_q.pop_front());
        end else chk("mem_addr_stable", o_mem_addr, cur);
        if (cnt == ack_delay) begin
          resp_ack = 1'b1;
          resp_data = mem_word(cur);
          in_req = 1'b0;
        end else cnt++;
      end else in_req = 1'b0;
    end
  end

  // Output monitor: pops the expected result on the first o_valid cycle, holds i_ready as asked.
  initial begin
    exp_t cur;
    int   hold = 0;
    logic [31:0] s_d1 = '0, s_d2 = '0;
    forever begin
      @(negedge clk);
      if (o_valid) begin
        if (!in_done) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_valid actual=1 expected=0");
            i_ready = 1'b1;
            continue;
          end
          cur = exp_q.pop_front();
          in_done = 1'b1;
          hold = cur.hold;
          s_d1 = o_data1;
          s_d2 = o_data2;
          if (cur.lat != 0) chk("latency", 32'(cyc - cur.acc), 32'(cur.lat));
        end else begin
          chk("hold_data1", o_data1, s_d1);
          chk("hold_data2", o_data2, s_d2);
        end
        if (hold == 0) begin
          i_ready = 1'b1;
          chk("data1", o_data1, cur.d1);
          chk("data2", o_data2, cur.d2);
          chk("funct3", 32'(o_funct3), 32'(cur.f3));
          chk("lsu_addr", 32'(o_lsu_addr), 32'(cur.la));
          chk("misalign_err", 32'(o_misalign_err), 32'(cur.err));
          in_done = 1'b0;
        end else begin
          i_ready = 1'b0;
          hold--;
        end
      end else begin
        i_ready = 1'b1;
        if (in_done) begin
          checks++; errors++;
          $display("FAIL valid_dropped actual=0 expected=1");
          in_done = 1'b0;
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    bit ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && !in_done && o_req_ready === 1'b1) ok = 1'b1;
      n++;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL idle_timeout actual=busy expected=idle");
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [2:0] f3, input int dly, input int hold,
                       input int lat, input int nrd, input logic [31:0] ra1, input logic [31:0] ra2,
                       input logic [31:0] d1, input logic [31:0] d2, input logic err);
    exp_t e;
    wait_idle();
    ack_delay = dly;
    if (nrd > 0) addr_q.push_back(ra1);
    if (nrd > 1) addr_q.push_back(ra2);
    e.d1 = d1; e.d2 = d2; e.f3 = f3; e.la = a[1:0]; e.err = err;
    e.hold = hold; e.lat = lat; e.acc = cyc;
    exp_q.push_back(e);
    i_req_valid = 1'b1; i_addr = a; i_funct3 = f3;
    @(posedge clk); #1;
    i_req_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] target;
    bit          seen;
    rst = 1'b1; i_req_valid = 1'b0; i_addr = '0; i_funct3 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("rst_req_ready", 32'(o_req_ready), 32'd1);
    chk("rst_mem_req", 32'(o_mem_req), 32'd0);
    chk("rst_mem_addr", o_mem_addr, 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_data1", o_data1, 32'd0);
    chk("rst_data2", o_data2, 32'd0);
    chk("rst_funct3", 32'(o_funct3), 32'd0);
    chk("rst_lsu_addr", 32'(o_lsu_addr), 32'd0);
    chk("rst_misalign", 32'(o_misalign_err), 32'd0);

    //     addr          f3      dly hold lat n  rd1           rd2           d1            d2            err
    issue(32'h0000_0100, F3_LW,  0,  0,   2,  1, 32'h0000_0100, 32'h0,        32'h1122_3344, 32'h0,        1'b0);
    issue(32'h0000_0107, F3_LB,  1,  0,   0,  1, 32'h0000_0104, 32'h0,        32'h5566_7788, 32'h0,        1'b0);
    issue(32'h0000_0102, F3_LHU, 3,  2,   0,  1, 32'h0000_0100, 32'h0,        32'h1122_3344, 32'h0,        1'b0);
    issue(32'hFFFF_FFFF, F3_LBU, 0,  0,   2,  1, 32'hFFFF_FFFC, 32'h0,        32'hDEAD_BEEF, 32'h0,        1'b0);
    issue(32'h0000_0101, F3_LH,  0,  1,   2,  1, 32'h0000_0100, 32'h0,        32'h1122_3344, 32'h0,        1'b0);
    issue(32'h0000_0100, 3'b011, 0,  0,   0,  0, 32'h0,         32'h0,        32'h0,         32'h0,        1'b0);
    issue(32'h0000_0205, 3'b110, 0,  0,   0,  0, 32'h0,         32'h0,        32'h0,         32'h0,        1'b0);
    issue(32'h0000_0206, 3'b111, 0,  1,   0,  0, 32'h0,         32'h0,        32'h0,         32'h0,        1'b0);
`ifdef LSU_MISALIGN_EN
    issue(32'h0000_0103, F3_LW,  0,  0,   3,  2, 32'h0000_0100, 32'h0000_0104, 32'h1122_3344, 32'h5566_7788, 1'b0);
    issue(32'hFFFF_FFFF, F3_LH,  0,  0,   3,  2, 32'hFFFF_FFFC, 32'h0000_0000, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0);
    issue(32'h0000_0107, F3_LHU, 2,  1,   0,  2, 32'h0000_0104, 32'h0000_0108, 32'h5566_7788, 32'h0108_FEF7, 1'b0);
`else
    issue(32'h0000_0102, F3_LW,  0,  0,   0,  0, 32'h0,         32'h0,        32'h0,         32'h0,        1'b1);
    issue(32'hFFFF_FFFF, F3_LH,  0,  0,   0,  0, 32'h0,         32'h0,        32'h0,         32'h0,        1'b1);
    issue(32'h0000_0101, F3_LW,  0,  1,   0,  0, 32'h0,         32'h0,        32'h0,         32'h0,        1'b1);
`endif

    // Abort a read in flight with reset; no result is expected from it.
    wait_idle();
    ack_delay = 5;
`ifdef LSU_MISALIGN_EN
    addr_q.push_back(32'h0000_0100);
    addr_q.push_back(32'h0000_0104);
    target = 32'h0000_0104;
    i_addr = 32'h0000_0103; i_funct3 = F3_LH;
`else
    addr_q.push_back(32'h0000_0200);
    target = 32'h0000_0200;
    i_addr = 32'h0000_0200; i_funct3 = F3_LW;
`endif
    i_req_valid = 1'b1;
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk); #1;
      if (o_mem_req && o_mem_addr == target) seen = 1'b1;
    end
    chk("abort_target_reached", 32'(seen), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_mem_req", 32'(o_mem_req), 32'd0);
    chk("abort_mem_addr", o_mem_addr, 32'd0);
    chk("abort_valid", 32'(o_valid), 32'd0);
    chk("abort_req_ready", 32'(o_req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    stray_data = 32'hBADB_AD00;
    stray_ack = 1'b1;
    repeat (2) @(negedge clk);
    stray_ack = 1'b0;
    #1;
    chk("stray_valid", 32'(o_valid), 32'd0);
    chk("stray_mem_req", 32'(o_mem_req), 32'd0);
    chk("stray_data1", o_data1, 32'd0);

    issue(32'h0000_0104, F3_LW, 0, 0, 2, 1, 32'h0000_0104, 32'h0, 32'h5566_7788, 32'h0, 1'b0);
    wait_idle();
    chk("pending_reads", 32'(addr_q.size()), 32'd0);
    chk("pending_results", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
